// File: rtl/pipe_pkg.sv
// Shared types and defaults for the hazard scoreboard: pipe-entry layout,
// forward-select encoding and the entry/source match helper.
package pipe_pkg;

  localparam int NUM_REGS_DEF     = 32;
  localparam int PIPE_DEPTH_DEF   = 3;
  localparam int LONG_LAT_MAX_DEF = 34;
  localparam int FW_NONE          = 0;

  // rd field is sized for up to 256 registers; narrower indices are zero-extended
  localparam int ENTRY_RD_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [ENTRY_RD_W-1:0] rd;
    logic                  regwrite;
    logic                  load;
  } pipe_entry_t;

  function automatic logic entry_match(input pipe_entry_t e,
                                       input logic [ENTRY_RD_W-1:0] src);
    return e.valid && e.regwrite && (e.rd != {ENTRY_RD_W{1'b0}}) && (e.rd == src);
  endfunction

endpackage

// File: rtl/sb_busy_table.sv
// One pending-write bit per register for the multi-cycle unit; set beats clear,
// and busy_eff already hides a bit being cleared this cycle.
module sb_busy_table
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int RW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                set_en,
  input  logic [RW-1:0]       set_idx,
  input  logic                clr_en,
  input  logic [RW-1:0]       clr_idx,
  output logic [NUM_REGS-1:0] busy_eff
);

  localparam logic [NUM_REGS-1:0] ONE  = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] ZERO = {NUM_REGS{1'b0}};

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] busy_nxt_s;

  // next-state masks; register 0 can never become busy
  always_comb begin
    set_mask_s = (set_en && (set_idx != {RW{1'b0}})) ? (ONE << set_idx) : ZERO;
    clr_mask_s = clr_en ? (ONE << clr_idx) : ZERO;
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~ONE;
  end

  // busy bit storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r <= ZERO;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_eff = busy_r & ~clr_mask_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard unit: EX forwarding selects, load-use / long-op
// RAW-WAW / structural stalls, branch flush, long-op watchdog and event counters.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int PIPE_DEPTH   = PIPE_DEPTH_DEF,
  parameter int LONG_LAT_MAX = LONG_LAT_MAX_DEF,
  parameter int FW_W         = $clog2(PIPE_DEPTH),
  localparam int RW          = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [RW-1:0]   rs1_ID,
  input  logic [RW-1:0]   rs2_ID,
  input  logic            use_rs1_ID,
  input  logic            use_rs2_ID,
  input  logic            long_ID,
  input  logic [RW-1:0]   rd_ID,
  input  logic            regwrite_ID,
  input  logic            issue,
  input  logic            load_ID,
  input  logic [RW-1:0]   rs1_EX,
  input  logic [RW-1:0]   rs2_EX,
  input  logic            btaken_EX,
  input  logic            long_done,
  input  logic [RW-1:0]   long_rd,
  output logic [FW_W-1:0] forward_A,
  output logic [FW_W-1:0] forward_B,
  output logic            stall,
  output logic            flush,
  output logic            long_busy,
  output logic            long_timeout,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  localparam int              LAT_W   = $clog2(LONG_LAT_MAX + 2);
  localparam logic [LAT_W-1:0] LAT_LIM = LAT_W'(LONG_LAT_MAX);
  localparam logic [LAT_W-1:0] LAT_SAT = LAT_W'(LONG_LAT_MAX + 1);
  localparam logic [31:0]      CNT_SAT = 32'hFFFF_FFFF;

  pipe_entry_t         pipe_r [PIPE_DEPTH];
  pipe_entry_t         entry_in_s;
  logic [NUM_REGS-1:0] busy_eff_s;
  logic                load_use_s, raw_s, struct_s, stall_s, flush_s;
  logic                accept_s, long_accept_s;
  logic [FW_W-1:0]     fwd_a_s, fwd_b_s;
  logic                long_busy_r, long_timeout_r;
  logic [LAT_W-1:0]    lat_cnt_r;
  logic [31:0]         stall_cnt_r, flush_cnt_r;

  assign flush_s = btaken_EX;

  // stall sources; a taken branch overrides every stall and kills the ID slot
  always_comb begin
    load_use_s = pipe_r[0].valid && pipe_r[0].load &&
                 ((use_rs1_ID && entry_match(pipe_r[0], ENTRY_RD_W'(rs1_ID))) ||
                  (use_rs2_ID && entry_match(pipe_r[0], ENTRY_RD_W'(rs2_ID))));
    raw_s      = (use_rs1_ID && busy_eff_s[rs1_ID]) ||
                 (use_rs2_ID && busy_eff_s[rs2_ID]) ||
                 (regwrite_ID && busy_eff_s[rd_ID]);
    struct_s   = long_ID && long_busy_r && !long_done;
    stall_s    = (load_use_s || raw_s || struct_s) && !flush_s;
    accept_s      = issue && !stall_s && !flush_s;
    long_accept_s = accept_s && long_ID;
  end

  // value shifted into the EX slot: the accepted short op, else a bubble
  always_comb begin
    if (accept_s && !long_ID) begin
      entry_in_s.valid    = 1'b1;
      entry_in_s.rd       = ENTRY_RD_W'(rd_ID);
      entry_in_s.regwrite = regwrite_ID;
      entry_in_s.load     = load_ID;
    end else begin
      entry_in_s = {$bits(pipe_entry_t){1'b0}};
    end
  end

  // forward select: walk from the oldest stage down so the youngest match wins
  always_comb begin
    fwd_a_s = FW_W'(FW_NONE);
    fwd_b_s = FW_W'(FW_NONE);
    for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
      fwd_a_s = entry_match(pipe_r[k], ENTRY_RD_W'(rs1_EX)) ? FW_W'(k) : fwd_a_s;
      fwd_b_s = entry_match(pipe_r[k], ENTRY_RD_W'(rs2_EX)) ? FW_W'(k) : fwd_b_s;
    end
  end

  // stage shift pipe, advancing every cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        pipe_r[k] <= {$bits(pipe_entry_t){1'b0}};
      end
    end else begin
      pipe_r[0] <= entry_in_s;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  sb_busy_table #(
    .NUM_REGS (NUM_REGS),
    .RW       (RW)
  ) u_busy (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (long_accept_s),
    .set_idx  (rd_ID),
    .clr_en   (long_done),
    .clr_idx  (long_rd),
    .busy_eff (busy_eff_s)
  );

  // long-unit occupancy and latency watchdog; timeout trips on the edge the count passes the limit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      long_busy_r    <= 1'b0;
      lat_cnt_r      <= {LAT_W{1'b0}};
      long_timeout_r <= 1'b0;
    end else begin
      long_busy_r    <= long_accept_s ? 1'b1 : (long_done ? 1'b0 : long_busy_r);
      lat_cnt_r      <= long_accept_s ? {LAT_W{1'b0}} :
                        ((long_busy_r && (lat_cnt_r != LAT_SAT)) ? lat_cnt_r + LAT_W'(1) : lat_cnt_r);
      long_timeout_r <= long_timeout_r ||
                        (long_busy_r && !long_accept_s && (lat_cnt_r >= LAT_LIM));
    end
  end

  // saturating stall / flush event counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= (stall_s && (stall_cnt_r != CNT_SAT)) ? stall_cnt_r + 32'd1 : stall_cnt_r;
      flush_cnt_r <= (flush_s && (flush_cnt_r != CNT_SAT)) ? flush_cnt_r + 32'd1 : flush_cnt_r;
    end
  end

  assign forward_A    = fwd_a_s;
  assign forward_B    = fwd_b_s;
  assign stall        = stall_s;
  assign flush        = flush_s;
  assign long_busy    = long_busy_r;
  assign long_timeout = long_timeout_r;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, architectural register count; register index width RW = $clog2(NUM_REGS).
REQ-002 Parameter PIPE_DEPTH, default 3, tracked stages after ID: index 0 = EX, 1 = MEM, 2 = WB, and so on.
REQ-003 Parameter LONG_LAT_MAX, default 34, maximum legal long-op latency in cycles.
REQ-004 Parameter FW_W, default $clog2(PIPE_DEPTH), forward-select width.
REQ-005 Ports:
- clk  in  1  single clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- rs1_ID, rs2_ID  in  RW  ID-stage source registers.
- use_rs1_ID, use_rs2_ID  in  1  source actually read.
- long_ID  in  1  ID instruction targets the multi-cycle unit.
- rd_ID  in  RW  ID destination.
- regwrite_ID  in  1  ID instruction writes rd.
- issue  in  1  ID instruction enters EX this cycle.
- load_ID  in  1  issued instruction is a load.
- rs1_EX, rs2_EX  in  RW  EX-stage sources.
- btaken_EX  in  1  branch/jump taken in EX.
- long_done  in  1  multi-cycle unit result written back this cycle.
- long_rd  in  RW  destination of long_done.
- forward_A, forward_B  out  FW_W  EX operand source: 0 = register file, k = stage k.
- stall  out  1  hold IF/ID, bubble into EX.
- flush  out  1  kill IF/ID contents.
- long_busy  out  1  multi-cycle unit occupied.
- long_timeout  out  1  sticky error.
- stall_cnt, flush_cnt  out  32  saturating event counters.

Function
REQ-006 The block SHALL keep a PIPE_DEPTH-entry shift pipe of {valid, rd, regwrite, load} that advances every cycle.
REQ-007 Entry 0 SHALL load {issue & ~long_ID & ~stall & ~flush, rd_ID, regwrite_ID, load_ID}; otherwise entry 0 SHALL receive a bubble.
REQ-008 An entry SHALL match source s only when valid & regwrite & rd != 0 & rd == s.
REQ-009 forward_A SHALL select the lowest-index stage k in 1..PIPE_DEPTH-1 whose entry matches rs1_EX, or 0 if none matches; forward_B SHALL do the same for rs2_EX. Both are combinational.
REQ-010 Load-use stall: stall SHALL assert when entry 0 is valid with load=1 and matches rs1_ID with use_rs1_ID, or matches rs2_ID with use_rs2_ID.
REQ-011 Busy table: one bit per register; bit rd_ID SHALL set on issue & long_ID & ~stall & ~flush when rd_ID != 0; bit long_rd SHALL clear on long_done; when set and clear hit the same bit in one cycle, set SHALL win.
REQ-012 RAW/WAW stall: stall SHALL assert when a used source is busy, or when regwrite_ID is set and busy[rd_ID] is set; a busy register cleared by long_done in the same cycle SHALL not count as busy.
REQ-013 Structural stall: stall SHALL assert when long_ID & long_busy & ~long_done.
REQ-014 long_busy SHALL set on an accepted long issue and clear on long_done, with set winning on a simultaneous event.
REQ-015 A latency counter SHALL reset to 0 on each accepted long issue and increment while long_busy is set; when it exceeds LONG_LAT_MAX, long_timeout SHALL set and hold until reset.
REQ-016 flush SHALL equal btaken_EX combinationally.
REQ-017 When flush and stall are both active, flush SHALL win: stall SHALL be forced to 0 and the ID instruction SHALL not be accepted.
REQ-018 stall_cnt SHALL increment on each stall cycle and flush_cnt on each flush cycle; both SHALL saturate at 0xFFFF_FFFF.
REQ-019 Register 0 SHALL never stall, never forward and never be marked busy.

Reset
REQ-020 On rstn low, asynchronously: all pipe entries invalid, busy table 0, long_busy 0, latency counter 0, long_timeout 0, stall_cnt 0, flush_cnt 0.
REQ-021 With state reset, all outputs SHALL read 0.
REQ-022 A long op in flight when reset asserts SHALL be forgotten; a later long_done SHALL only clear busy bits, which are already 0.

Structure
REQ-023 Package pipe_pkg SHALL hold the pipe-entry struct typedef, the FW_NONE = 0 constant and the default parameter values.
REQ-024 One sub-module, sb_busy_table, SHALL hold the busy bits plus set/clear logic.

Verification
REQ-025 Bench SHALL cover these scenarios:
- ALU x5 issued, then EX rs1 = 5 one cycle later -> forward_A = 1; two cycles later -> forward_A = 2.
- Load x7, next ID uses rs2 = 7 -> stall = 1 for exactly 1 cycle, stall_cnt = 1, then forward_B = 2.
- Long op to x9, ID reads x9 -> stall held until long_done with long_rd = 9, releasing in the same cycle.
- Branch taken while a load-use stall is pending -> flush = 1, stall = 0, no pipe entry inserted.
- Long op issued with long_done withheld -> long_timeout = 1 after LONG_LAT_MAX + 1 cycles and stays 1.
- Write x0 followed by a read of x0 -> no stall, forward = 0; rstn pulsed mid long op -> long_busy = 0.
